// File: rtl/updown_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : updown_step_sequencer
//  Description : Command front-end for an up/down counter. Accepts step-up,
//                step-down and load commands over valid/ready, refuses any
//                command that would push the count outside
//                [MIN_COUNT, MAX_COUNT], then drives the counter's
//                run/up_down/wren/write_data pins. Each command ends with a
//                one-cycle response pulse. A sticky error flag records
//                refusals.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_step_sequencer #(
  parameter int unsigned                WORD_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0]      MIN_COUNT  = '0,
  // All-ones by default, which is 255 at the default width.
  parameter logic [WORD_WIDTH-1:0]      MAX_COUNT  = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WORD_WIDTH-1:0] cmd_data,
  input  logic [WORD_WIDTH-1:0] count_in,
  output logic                  ctr_run,
  output logic                  ctr_up_down,
  output logic                  ctr_wren,
  output logic [WORD_WIDTH-1:0] ctr_write_data,
  output logic                  rsp_valid,
  output logic                  rsp_ok,
  output logic                  err_sticky,
  input  logic                  err_clear
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Bounds widened by one bit so that the sum/floor arithmetic below can
  // never truncate, even with all-ones operands.
  localparam logic [WORD_WIDTH:0]   c_MIN_EXT = {1'b0, MIN_COUNT};
  localparam logic [WORD_WIDTH:0]   c_MAX_EXT = {1'b0, MAX_COUNT};
  localparam logic [WORD_WIDTH-1:0] c_ONE     = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [WORD_WIDTH-1:0] r_remaining;
  logic                  r_dir;
  logic [WORD_WIDTH-1:0] r_load_val;
  logic                  r_ok;
  logic                  r_err;

  logic [WORD_WIDTH:0]   w_n_ext;
  logic [WORD_WIDTH:0]   w_cnt_ext;
  logic [WORD_WIDTH:0]   w_up_sum;
  logic [WORD_WIDTH:0]   w_dn_floor;
  logic                  w_n_zero;
  logic                  w_up_legal;
  logic                  w_dn_legal;
  logic                  w_ld_legal;
  logic                  w_accept;
  logic                  w_refuse;

  assign w_n_ext    = {1'b0, cmd_data};
  assign w_cnt_ext  = {1'b0, count_in};
  assign w_up_sum   = w_cnt_ext + w_n_ext;
  assign w_dn_floor = c_MIN_EXT + w_n_ext;
  assign w_n_zero   = (cmd_data == '0);
  assign w_up_legal = (w_up_sum <= c_MAX_EXT);
  assign w_dn_legal = (w_cnt_ext >= w_dn_floor);
  assign w_ld_legal = (w_n_ext >= c_MIN_EXT) && (w_n_ext <= c_MAX_EXT);
  assign w_accept   = cmd_valid && (r_state == S_IDLE);

  // Decide at acceptance time whether the command must be refused.
  always_comb begin
    w_refuse = 1'b0;
    if (w_accept) begin
      case (cmd_op)
        OP_UP:   w_refuse = !w_n_zero && !w_up_legal;
        OP_DOWN: w_refuse = !w_n_zero && !w_dn_legal;
        OP_LOAD: w_refuse = !w_ld_legal;
        default: w_refuse = 1'b0;
      endcase
    end
  end

  // Command FSM: evaluate in IDLE, run N step cycles or one load cycle,
  // then a single response cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_load_val  <= '0;
      r_ok        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              OP_UP, OP_DOWN: begin
                if (w_refuse) begin
                  r_state <= S_RESP;
                  r_ok    <= 1'b0;
                end else if (w_n_zero) begin
                  r_state <= S_RESP;
                  r_ok    <= 1'b1;
                end else begin
                  r_state     <= S_STEP;
                  r_remaining <= cmd_data;
                  r_dir       <= (cmd_op == OP_UP);
                end
              end
              OP_LOAD: begin
                if (w_refuse) begin
                  r_state <= S_RESP;
                  r_ok    <= 1'b0;
                end else begin
                  r_state    <= S_LOAD;
                  r_load_val <= cmd_data;
                end
              end
              default: r_state <= S_IDLE;  // no-op: swallowed silently
            endcase
          end
        end
        S_STEP: begin
          // remaining is never zero here; the last run cycle is the one
          // that sees remaining == 1.
          r_remaining <= r_remaining - c_ONE;
          if (r_remaining == c_ONE) begin
            r_state <= S_RESP;
            r_ok    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_RESP;
          r_ok    <= 1'b1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error: a refusal in the same cycle as a clear takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_refuse) begin
      r_err <= 1'b1;
    end else if (err_clear) begin
      r_err <= 1'b0;
    end
  end

  // All outputs are decoded from registered state only.
  assign cmd_ready      = (r_state == S_IDLE);
  assign ctr_run        = (r_state == S_STEP);
  assign ctr_up_down    = (r_state == S_STEP) && r_dir;
  assign ctr_wren       = (r_state == S_LOAD);
  assign ctr_write_data = (r_state == S_LOAD) ? r_load_val : '0;
  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_ok         = (r_state == S_RESP) && r_ok;
  assign err_sticky     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_updown_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_step_sequencer
//  Description : Self-checking bench. Two sequencers (full range and a
//                narrowed [20,150] range) each drive a behavioural counter.
//                Commands are checked against a transaction-level model of
//                legality, latency and final count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_step_sequencer;

  localparam int W = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        cmd_valid = '0;
  logic [1:0]        cmd_ready;
  logic [1:0][1:0]   cmd_op = '0;
  logic [1:0][W-1:0] cmd_data = '0;
  logic [1:0]        err_clear = '0;
  logic [1:0]        ctr_run;
  logic [1:0]        ctr_up_down;
  logic [1:0]        ctr_wren;
  logic [1:0][W-1:0] ctr_write_data;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ok;
  logic [1:0]        err_sticky;
  logic [1:0][W-1:0] cnt = '0;

  int n_pass  = 0;
  int n_total = 0;
  bit [1:0] mdl_err = '0;
  int mins[2] = '{0, 20};
  int maxs[2] = '{255, 150};
  bit mon_en = 1'b0;

  always #5 clock = ~clock;

  updown_step_sequencer #(.WORD_WIDTH(W), .MIN_COUNT(8'd0), .MAX_COUNT(8'd255)) u_dut0 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]), .count_in(cnt[0]),
    .ctr_run(ctr_run[0]), .ctr_up_down(ctr_up_down[0]), .ctr_wren(ctr_wren[0]),
    .ctr_write_data(ctr_write_data[0]), .rsp_valid(rsp_valid[0]), .rsp_ok(rsp_ok[0]),
    .err_sticky(err_sticky[0]), .err_clear(err_clear[0])
  );

  updown_step_sequencer #(.WORD_WIDTH(W), .MIN_COUNT(8'd20), .MAX_COUNT(8'd150)) u_dut1 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]), .count_in(cnt[1]),
    .ctr_run(ctr_run[1]), .ctr_up_down(ctr_up_down[1]), .ctr_wren(ctr_wren[1]),
    .ctr_write_data(ctr_write_data[1]), .rsp_valid(rsp_valid[1]), .rsp_ok(rsp_ok[1]),
    .err_sticky(err_sticky[1]), .err_clear(err_clear[1])
  );

  // Downstream counters (never reset by the sequencer).
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (ctr_wren[d])     cnt[d] <= ctr_write_data[d];
      else if (ctr_run[d]) cnt[d] <= ctr_up_down[d] ? cnt[d] + 8'd1 : cnt[d] - 8'd1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    n_total++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
  endtask

  // Per-cycle invariants.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      for (int d = 0; d < 2; d++) begin
        chk("run_wren_exclusive", ctr_run[d] & ctr_wren[d], 0);
        chk("ready_low_when_busy", (ctr_run[d] | ctr_wren[d] | rsp_valid[d]) & cmd_ready[d], 0);
        if (!ctr_wren[d]) chk("wdata_zero_outside_load", ctr_write_data[d], 0);
      end
    end
  end

  // Issue one command and check it against the transaction-level model.
  task automatic do_cmd(input int d, input logic [1:0] op, input logic [W-1:0] n, input bit clr);
    int  waitc = 0, exp_lat = 0, exp_ok = 0, exp_runs = 0, exp_wrens = 0;
    int  lat = 0, ok = 0, runs = 0, wrens = 0, bad_dir = 0, bad_wd = 0;
    int  cur, exp_cnt, bound, nn;
    bit  refused = 1'b0;
    @(negedge clock);
    while (!cmd_ready[d] && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    chk("ready_before_cmd", cmd_ready[d], 1);
    cur = int'(cnt[d]);
    nn  = int'(n);
    exp_cnt = cur;
    case (op)
      2'b01: begin
        if (nn == 0) begin exp_lat = 1; exp_ok = 1; end
        else if (cur + nn <= maxs[d]) begin
          exp_lat = nn + 1; exp_ok = 1; exp_runs = nn; exp_cnt = cur + nn;
        end else begin exp_lat = 1; refused = 1'b1; end
      end
      2'b10: begin
        if (nn == 0) begin exp_lat = 1; exp_ok = 1; end
        else if (cur >= mins[d] + nn) begin
          exp_lat = nn + 1; exp_ok = 1; exp_runs = nn; exp_cnt = cur - nn;
        end else begin exp_lat = 1; refused = 1'b1; end
      end
      2'b11: begin
        if (nn >= mins[d] && nn <= maxs[d]) begin
          exp_lat = 2; exp_ok = 1; exp_wrens = 1; exp_cnt = nn;
        end else begin exp_lat = 1; refused = 1'b1; end
      end
      default: exp_lat = 0;
    endcase
    if (refused)  mdl_err[d] = 1'b1;
    else if (clr) mdl_err[d] = 1'b0;
    bound = (exp_lat == 0) ? 3 : exp_lat + 4;
    cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_data[d] = n; err_clear[d] = clr;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clock);
      if (c == 1) begin cmd_valid[d] = 1'b0; err_clear[d] = 1'b0; end
      if (ctr_run[d]) begin
        runs++;
        if (ctr_up_down[d] != (op == 2'b01)) bad_dir++;
      end
      if (ctr_wren[d]) begin
        wrens++;
        if (ctr_write_data[d] != n) bad_wd++;
      end
      if (rsp_valid[d]) begin
        lat = c; ok = int'(rsp_ok[d]);
        break;
      end
    end
    chk("rsp_latency", lat, exp_lat);
    if (lat > 0) chk("rsp_ok", ok, exp_ok);
    chk("run_cycles", runs, exp_runs);
    chk("wren_cycles", wrens, exp_wrens);
    chk("run_direction_errors", bad_dir, 0);
    chk("write_data_errors", bad_wd, 0);
    chk("final_count", cnt[d], exp_cnt);
    chk("err_sticky", err_sticky[d], mdl_err[d]);
    if (lat > 0) begin
      @(negedge clock);
      chk("rsp_single_cycle", rsp_valid[d], 0);
    end
  endtask

  task automatic clear_err(input int d);
    @(negedge clock);
    err_clear[d] = 1'b1;
    @(negedge clock);
    err_clear[d] = 1'b0;
    mdl_err[d] = 1'b0;
    chk("err_after_clear", err_sticky[d], 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int start;
    int delta;
    int rsp_cyc[$];
    int rsp_seen;

    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("reset_cmd_ready", cmd_ready[d], 1);
      chk("reset_ctr_run", ctr_run[d], 0);
      chk("reset_ctr_up_down", ctr_up_down[d], 0);
      chk("reset_ctr_wren", ctr_wren[d], 0);
      chk("reset_write_data", ctr_write_data[d], 0);
      chk("reset_rsp_valid", rsp_valid[d], 0);
      chk("reset_rsp_ok", rsp_ok[d], 0);
      chk("reset_err", err_sticky[d], 0);
    end
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic step up, refused step down, error clear / set-wins.
    do_cmd(0, 2'b11, 8'd5, 1'b0);
    do_cmd(0, 2'b01, 8'd3, 1'b0);
    do_cmd(0, 2'b11, 8'd2, 1'b0);
    do_cmd(0, 2'b10, 8'd3, 1'b0);
    clear_err(0);
    do_cmd(0, 2'b10, 8'd3, 1'b1);
    do_cmd(0, 2'b10, 8'd2, 1'b1);
    do_cmd(0, 2'b11, 8'd200, 1'b0);
    do_cmd(1, 2'b11, 8'd200, 1'b0);
    clear_err(1);

    // Upper extremes: saturate exactly, then refuse without wrapping.
    do_cmd(0, 2'b11, 8'd250, 1'b0);
    do_cmd(0, 2'b01, 8'd5, 1'b0);
    do_cmd(0, 2'b01, 8'd1, 1'b0);
    do_cmd(0, 2'b11, 8'd1, 1'b0);
    do_cmd(0, 2'b01, 8'd255, 1'b0);
    do_cmd(0, 2'b10, 8'd1, 1'b0);
    do_cmd(0, 2'b10, 8'd1, 1'b0);
    do_cmd(0, 2'b01, 8'd0, 1'b0);
    do_cmd(0, 2'b10, 8'd0, 1'b0);
    do_cmd(0, 2'b00, 8'd7, 1'b0);

    // Narrow-range instance: bounds on both sides.
    do_cmd(1, 2'b11, 8'd25, 1'b0);
    do_cmd(1, 2'b10, 8'd5, 1'b0);
    do_cmd(1, 2'b10, 8'd1, 1'b0);
    do_cmd(1, 2'b11, 8'd19, 1'b0);
    do_cmd(1, 2'b11, 8'd150, 1'b0);
    do_cmd(1, 2'b11, 8'd151, 1'b0);
    do_cmd(1, 2'b01, 8'd1, 1'b0);

    // Back-to-back up-by-1 with valid held high.
    do_cmd(0, 2'b11, 8'd10, 1'b0);
    @(negedge clock);
    start = int'(cnt[0]);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b01; cmd_data[0] = 8'd1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      if (rsp_valid[0]) begin
        rsp_cyc.push_back(c);
        if (rsp_cyc.size() == 3) begin
          cmd_valid[0] = 1'b0;
          break;
        end
      end
    end
    cmd_valid[0] = 1'b0;
    chk("b2b_rsp_count", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      chk("b2b_first_rsp", rsp_cyc[0], 2);
      chk("b2b_spacing_1", rsp_cyc[1] - rsp_cyc[0], 3);
      chk("b2b_spacing_2", rsp_cyc[2] - rsp_cyc[1], 3);
    end
    chk("b2b_count", cnt[0], start + 3);
    chk("b2b_ok", rsp_ok[0], 1);

    // Reset in the 2nd cycle of an N=4 step.
    do_cmd(0, 2'b11, 8'd100, 1'b0);
    @(negedge clock);
    start = int'(cnt[0]);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b01; cmd_data[0] = 8'd4;
    @(negedge clock);
    cmd_valid[0] = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_run", ctr_run[0], 0);
    chk("rst_mid_up_down", ctr_up_down[0], 0);
    chk("rst_mid_ready", cmd_ready[0], 1);
    chk("rst_mid_rsp", rsp_valid[0], 0);
    mdl_err = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (rsp_valid[0]) rsp_seen++;
    end
    chk("rst_no_rsp", rsp_seen, 0);
    delta = int'(cnt[0]) - start;
    chk("rst_counter_advanced_1_or_2", (delta >= 1 && delta <= 2) ? 1 : 0, 1);
    chk("rst_err0", err_sticky[0], 0);
    chk("rst_err1", err_sticky[1], 0);
    do_cmd(0, 2'b01, 8'd2, 1'b0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 120; i++) begin
      int d, sel;
      logic [1:0] op;
      logic [W-1:0] n;
      d   = int'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       n = 8'($urandom_range(0, 6));
        1:       n = 8'($urandom);
        2:       n = ($urandom_range(0, 1) == 0) ? 8'd255 : 8'd1;
        default: n = 8'(maxs[d] - int'(cnt[d]) + int'($urandom_range(0, 1)));
      endcase
      do_cmd(d, op, n, $urandom_range(0, 7) == 0);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
